// File: rtl/entropy_alert_fsm.sv
// Debounced alert level from the entropy class stream: fast escalation, slow
// de-escalation, sticky critical interrupt and sticky illegal-class flag.
module entropy_alert_fsm #(
  parameter int ESCALATE_COUNT   = 4,
  parameter int DEESCALATE_COUNT = 8,
  parameter int CNT_W            = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       class_valid,
  input  logic [1:0] signal_class,
  input  logic       alert_ack,
  output logic [1:0] alert_level,
  output logic       level_change,
  output logic       critical_irq,
  output logic       class_err
);

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_MID  = 2'b01,
    S_CRIT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] ESC_LAST   = CNT_W'(ESCALATE_COUNT - 1);
  localparam logic [CNT_W-1:0] DEESC_LAST = CNT_W'(DEESCALATE_COUNT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] esc_q, esc_d, deesc_q, deesc_d;
  logic             chg_q, chg_d, irq_q, irq_d, err_q, err_d;
  logic [1:0]       eff_class, lvl;

  // Illegal 2'b11 is folded onto CRITICAL so a broken decoder fails safe.
  assign eff_class = (signal_class == 2'b11) ? 2'b10 : signal_class;
  assign lvl       = state_q;

  always_comb begin
    state_d = state_q;
    esc_d   = esc_q;
    deesc_d = deesc_q;
    chg_d   = 1'b0;
    irq_d   = irq_q;
    err_d   = err_q;
    if (class_valid) begin
      if (signal_class == 2'b11) err_d = 1'b1;
      if (eff_class > lvl) begin
        deesc_d = '0;
        if (esc_q >= ESC_LAST) begin
          state_d = (state_q == S_LOW) ? S_MID : S_CRIT;
          esc_d   = '0;
          chg_d   = 1'b1;
        end else begin
          esc_d = esc_q + 1'b1;
        end
      end else if (eff_class < lvl) begin
        esc_d = '0;
        if (deesc_q >= DEESC_LAST) begin
          // An unacknowledged critical interrupt pins the level; the counter
          // parks one short so the first sample after ack completes the step.
          if (state_q == S_CRIT && irq_q) begin
            deesc_d = DEESC_LAST;
          end else begin
            state_d = (state_q == S_CRIT) ? S_MID : S_LOW;
            deesc_d = '0;
            chg_d   = 1'b1;
          end
        end else begin
          deesc_d = deesc_q + 1'b1;
        end
      end else begin
        esc_d   = '0;
        deesc_d = '0;
      end
    end
    if (state_d == S_CRIT && state_q != S_CRIT) irq_d = 1'b1;
    else if (alert_ack)                          irq_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
      esc_q   <= '0;
      deesc_q <= '0;
      chg_q   <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      esc_q   <= esc_d;
      deesc_q <= deesc_d;
      chg_q   <= chg_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  end

  assign alert_level  = state_q;
  assign level_change = chg_q;
  assign critical_irq = irq_q;
  assign class_err    = err_q;

endmodule

// File: tb/tb_entropy_alert_fsm.sv
module tb_entropy_alert_fsm;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       class_valid;
  logic [1:0] signal_class;
  logic       alert_ack;
  logic [1:0] alert_level;
  logic       level_change, critical_irq, class_err;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];
  string      name_q[$];
  event       chk_ev;

  entropy_alert_fsm #(.ESCALATE_COUNT(4), .DEESCALATE_COUNT(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .class_valid(class_valid), .signal_class(signal_class),
    .alert_ack(alert_ack), .alert_level(alert_level), .level_change(level_change),
    .critical_irq(critical_irq), .class_err(class_err)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
        logic [4:0] e, a;
        string      n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a = {alert_level, level_change, critical_irq, class_err};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL %s: got lvl=%0d chg=%0b irq=%0b err=%0b, want lvl=%0d chg=%0b irq=%0b err=%0b",
                   n, a[4:3], a[2], a[1], a[0], e[4:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: stimulus did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic step(input logic v, input logic [1:0] c, input logic ack,
                      input logic [1:0] lvl, input logic chg, input logic irq,
                      input logic err, input string n);
    @(negedge clk);
    class_valid  = v;
    signal_class = c;
    alert_ack    = ack;
    exp_q.push_back({lvl, chg, irq, err});
    name_q.push_back(n);
  endtask

  task automatic mid_reset(input string n);
    @(negedge clk);
    class_valid = 1'b0;
    alert_ack   = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.push_back(5'b0);
    name_q.push_back(n);
    ->chk_ev;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    class_valid = 1'b0;
    signal_class = 2'b00;
    alert_ack = 1'b0;
    #2;
    total++;
    if ({alert_level, level_change, critical_irq, class_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_direct: outputs not cleared during reset");
    end
    #1;
    exp_q.push_back(5'b0);
    name_q.push_back("reset_state");
    ->chk_ev;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) step(1, 2'b01, 0, 2'd0, 0, 0, 0, "t1_hold");
    step(1, 2'b01, 0, 2'd1, 1, 0, 0, "t1_step");
    step(0, 2'b01, 0, 2'd1, 0, 0, 0, "t1_pulse_end");

    mid_reset("t2_reset");
    for (int i = 0; i < 8; i++) begin
      if (i == 3)      step(1, 2'b10, 0, 2'd1, 1, 0, 0, "t2_to_mid");
      else if (i == 7) step(1, 2'b10, 0, 2'd2, 1, 1, 0, "t2_to_crit");
      else             step(1, 2'b10, 0, (i < 3) ? 2'd0 : 2'd1, 0, 0, 0, "t2_hold");
    end

    for (int i = 0; i < 20; i++) step(1, 2'b00, 0, 2'd2, 0, 1, 0, "t3_blocked");
    step(0, 2'b00, 1, 2'd2, 0, 0, 0, "t3_ack");
    step(1, 2'b00, 0, 2'd1, 1, 0, 0, "t3_to_mid");
    for (int i = 0; i < 7; i++) step(1, 2'b00, 0, 2'd1, 0, 0, 0, "t3_mid_hold");
    step(1, 2'b00, 0, 2'd0, 1, 0, 0, "t3_to_low");
    step(0, 2'b00, 1, 2'd0, 0, 0, 0, "t3_ack_idle");

    mid_reset("t4_reset");
    step(1, 2'b01, 0, 2'd0, 0, 0, 0, "t4_a");
    step(1, 2'b01, 0, 2'd0, 0, 0, 0, "t4_b");
    step(1, 2'b01, 0, 2'd0, 0, 0, 0, "t4_c");
    step(1, 2'b00, 0, 2'd0, 0, 0, 0, "t4_break");
    for (int i = 0; i < 3; i++) step(1, 2'b01, 0, 2'd0, 0, 0, 0, "t4_rerun");
    step(1, 2'b01, 0, 2'd1, 1, 0, 0, "t4_step");

    mid_reset("t5_reset");
    for (int i = 0; i < 10; i++) begin
      if (i == 9)                          step(1, 2'b01, 0, 2'd1, 1, 0, 0, "t5_step");
      else if (i == 1 || i == 3 || i == 6) step(1, 2'b01, 0, 2'd0, 0, 0, 0, "t5_valid");
      else                                 step(0, 2'b10, 0, 2'd0, 0, 0, 0, "t5_invalid");
    end

    step(1, 2'b11, 0, 2'd1, 0, 0, 1, "t6_illegal");
    step(1, 2'b10, 0, 2'd1, 0, 0, 1, "t6_b");
    step(1, 2'b10, 0, 2'd1, 0, 0, 1, "t6_c");
    step(1, 2'b10, 1, 2'd2, 1, 1, 1, "t6_entry_wins");
    step(0, 2'b00, 0, 2'd2, 0, 1, 1, "t6_irq_held");
    step(1, 2'b01, 0, 2'd2, 0, 1, 1, "t6_err_sticky");
    mid_reset("t6_async_reset");
    step(0, 2'b00, 0, 2'd0, 0, 0, 0, "t6_post_reset");

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected results never checked", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
